// File: rtl/uart_buffer_tx.sv
// uart_buffer_tx: drains a byte circular buffer and shifts each byte out as an
// 8N1 frame (start, 8 data bits LSB first, stop) on tx.
module uart_buffer_tx #(
  parameter int unsigned BUFFER_BYTE_SIZE = 4,
  parameter int unsigned BUFFER_ADDR_SIZE = $clog2(BUFFER_BYTE_SIZE),
  parameter int unsigned CLKS_PER_BIT     = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_en,
  input  logic [BUFFER_ADDR_SIZE:0] buf_size_avai,
  input  logic [7:0]                buf_output_data,
  output logic                      buf_output_en,
  output logic                      tx,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int unsigned AVAI_W = BUFFER_ADDR_SIZE + 1;
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);

  localparam logic [AVAI_W-1:0] EMPTY_AVAI = AVAI_W'(BUFFER_BYTE_SIZE);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        IDX_LAST   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             start_ok;

  // Last cycle of the current bit time, and permission to begin a new frame.
  assign bit_end  = (cnt_q == BIT_LAST);
  assign start_ok = tx_en && (buf_size_avai != EMPTY_AVAI);

  // State and datapath registers; reset leaves the line idle and the pop low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      cnt_q     <= '0;
      tx_q      <= 1'b1;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: each phase advances on the last cycle of its bit time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && (bit_idx_q == IDX_LAST)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the shifter, counters and registered outputs.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    tx_d      = tx_q;
    pop_d     = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (start_ok) begin
          // Pop and start bit share an edge; the byte is taken before the
          // buffer's read pointer moves.
          shift_d = buf_output_data;
          pop_d   = 1'b1;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          // After bit 7 the line rises for the stop bit.
          tx_d      = (bit_idx_q == IDX_LAST) ? 1'b1 : shift_q[1];
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          tx_d   = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
    endcase
  end

  assign buf_output_en = pop_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_buffer_tx.sv
// Bench for uart_buffer_tx: a 4-deep buffer model feeds DUT A (4 clks/bit);
// DUT B (2 clks/bit) is fed by a one-byte holder for the boundary case.
// Per-cycle {tx,busy,pop,done} is logged and compared against a waveform
// model built from frame start times and bytes.
`timescale 1ns/1ps
module tb_uart_buffer_tx;

  localparam int unsigned CPB_A = 4;
  localparam int unsigned CPB_B = 2;
  localparam int unsigned DEPTH = 4;
  localparam int          LOGN  = 512;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_en = 1'b0;

  // Buffer model for DUT A
  logic              push_valid = 1'b0;
  logic [7:0]        push_data = 8'h00;
  logic [7:0]        mem [DEPTH] = '{default: 8'h00};
  int unsigned       wr_ptr = 0;
  int unsigned       rd_ptr = 0;
  int unsigned       count = 0;
  int unsigned       underflow = 0;

  logic [2:0] a_avai;
  logic [7:0] a_data;
  logic       a_pop, a_tx, a_busy, a_done;

  // One-byte holder for DUT B
  logic       b_load = 1'b0;
  logic       b_has = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_en = 1'b1;
  logic [2:0] b_avai;
  logic       b_pop, b_tx, b_busy, b_done;

  logic [3:0] obs_a [LOGN];
  logic [3:0] obs_b [LOGN];
  logic [3:0] exp_v [LOGN];
  int         exp_start [8];
  logic [7:0] exp_byte [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_buffer_tx #(.BUFFER_BYTE_SIZE(DEPTH), .CLKS_PER_BIT(CPB_A)) u_dut_a (
    .clk(clk), .reset(reset), .tx_en(tx_en),
    .buf_size_avai(a_avai), .buf_output_data(a_data),
    .buf_output_en(a_pop), .tx(a_tx), .busy(a_busy), .tx_done(a_done)
  );

  uart_buffer_tx #(.BUFFER_BYTE_SIZE(DEPTH), .CLKS_PER_BIT(CPB_B)) u_dut_b (
    .clk(clk), .reset(reset), .tx_en(b_en),
    .buf_size_avai(b_avai), .buf_output_data(b_data),
    .buf_output_en(b_pop), .tx(b_tx), .busy(b_busy), .tx_done(b_done)
  );

  // Circular buffer: pointer moves at the end of the pop cycle.
  always @(posedge clk) begin
    if (a_pop && count == 0) underflow <= underflow + 1;
    if (a_pop && count != 0) rd_ptr <= (rd_ptr + 1) % DEPTH;
    if (push_valid) begin
      mem[wr_ptr] <= push_data;
      wr_ptr <= (wr_ptr + 1) % DEPTH;
    end
    count <= count + (push_valid ? 1 : 0) - ((a_pop && count != 0) ? 1 : 0);
  end
  assign a_avai = 3'(DEPTH - count);
  assign a_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (b_load) b_has <= 1'b1;
    else if (b_pop) b_has <= 1'b0;
  end
  assign b_avai = b_has ? 3'd3 : 3'd4;

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = b;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  // Log n cycles at falling edges; optionally change tx_en after a sample.
  task automatic record(input int n, input int drop_at, input int raise_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_a[i] = {a_tx, a_busy, a_pop, a_done};
      obs_b[i] = {b_tx, b_busy, b_pop, b_done};
      if (i == drop_at) tx_en = 1'b0;
      if (i == raise_at) tx_en = 1'b1;
    end
  endtask

  // Expected line behaviour from frame start cycles and bytes.
  task automatic build_expect(input int n, input int c, input int nf);
    for (int i = 0; i < n; i++) begin
      logic e_tx, e_busy, e_pop, e_done;
      e_tx = 1'b1; e_busy = 1'b0; e_pop = 1'b0; e_done = 1'b0;
      for (int f = 0; f < nf; f++) begin
        int t;
        t = i - exp_start[f];
        if (t >= 0 && t < 10 * c) begin
          e_busy = 1'b1;
          if (t < c) e_tx = 1'b0;
          else if (t < 9 * c) e_tx = exp_byte[f][(t - c) / c];
          else e_tx = 1'b1;
        end
        if (t == 0) e_pop = 1'b1;
        if (t == 10 * c) e_done = 1'b1;
      end
      exp_v[i] = {e_tx, e_busy, e_pop, e_done};
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", a_tx); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    checks++; if (a_pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b want=0", a_pop); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", a_done); end
    checks++; if (b_tx !== 1'b1) begin failures++; $display("FAIL reset_tx_b got=%b want=1", b_tx); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte;
    int bad, first;
    tx_en = 1'b1;
    push_byte(8'hA5);
    record(60, -1, -1);
    exp_start[0] = 0; exp_byte[0] = 8'hA5;
    build_expect(60, CPB_A, 1);
    bad = 0; first = -1;
    for (int i = 0; i < 60; i++) if (obs_a[i] !== exp_v[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_byte %0d bad cycles, first at %0d got {tx,busy,pop,done}=%b want=%b",
               bad, first, obs_a[first], exp_v[first]);
    end
  endtask

  task automatic test_empty;
    int bad, first;
    tx_en = 1'b1;
    record(100, -1, -1);
    build_expect(100, CPB_A, 0);
    bad = 0; first = -1;
    for (int i = 0; i < 100; i++) if (obs_a[i] !== exp_v[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL empty_idle %0d bad cycles, first at %0d got=%b want=%b",
               bad, first, obs_a[first], exp_v[first]);
    end
  endtask

  // Queue nb bytes with tx_en low, then open the gate and check the drain.
  task automatic test_drain(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input bit rnd);
    int bad, first, n;
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    if (rnd) for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
    tx_en = 1'b0;
    for (int k = 0; k < nb; k++) push_byte(bytes[k]);
    tx_en = 1'b1;
    n = nb * (10 * CPB_A + 1) + 20;
    record(n, -1, -1);
    for (int k = 0; k < nb; k++) begin
      exp_start[k] = k * (10 * CPB_A + 1);
      exp_byte[k]  = bytes[k];
    end
    build_expect(n, CPB_A, nb);
    bad = 0; first = -1;
    for (int i = 0; i < n; i++) if (obs_a[i] !== exp_v[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL drain_%0d %0d bad cycles, first at %0d got=%b want=%b",
               nb, bad, first, obs_a[first], exp_v[first]);
    end
    checks++;
    if (a_avai !== 3'd4) begin failures++; $display("FAIL drain_empty avai got=%0d want=4", a_avai); end
  endtask

  task automatic test_gate;
    int bad, first;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    tx_en = 1'b0;
    push_byte(b1);
    push_byte(b2);
    tx_en = 1'b1;
    record(150, 12, 100);
    exp_start[0] = 0;   exp_byte[0] = b1;
    exp_start[1] = 101; exp_byte[1] = b2;
    build_expect(150, CPB_A, 2);
    bad = 0; first = -1;
    for (int i = 0; i < 150; i++) if (obs_a[i] !== exp_v[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL gate %0d bad cycles, first at %0d got=%b want=%b",
               bad, first, obs_a[first], exp_v[first]);
    end
  endtask

  task automatic test_async_reset;
    int bad, first;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    tx_en = 1'b0;
    push_byte(b1);
    push_byte(b2);
    tx_en = 1'b1;
    @(negedge clk);
    checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL areset_start tx got=%b want=0", a_tx); end
    repeat (18) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL areset_tx got=%b want=1", a_tx); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b want=0", a_busy); end
    checks++; if (a_pop !== 1'b0) begin failures++; $display("FAIL areset_pop got=%b want=0", a_pop); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    record(50, -1, -1);
    exp_start[0] = 0; exp_byte[0] = b2;
    build_expect(50, CPB_A, 1);
    bad = 0; first = -1;
    for (int i = 0; i < 50; i++) if (obs_a[i] !== exp_v[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL areset_restart %0d bad cycles, first at %0d got=%b want=%b",
               bad, first, obs_a[first], exp_v[first]);
    end
    checks++;
    if (a_avai !== 3'd4) begin failures++; $display("FAIL areset_empty avai got=%0d want=4", a_avai); end
  endtask

  task automatic test_boundary;
    int bad, first, busy_cnt;
    logic [7:0] b;
    for (int r = 0; r < 2; r++) begin
      b = (r == 0) ? 8'h80 : 8'($urandom);
      @(negedge clk);
      b_data = b;
      b_load = 1'b1;
      @(negedge clk);
      b_load = 1'b0;
      record(30, -1, -1);
      exp_start[0] = 0; exp_byte[0] = b;
      build_expect(30, CPB_B, 1);
      bad = 0; first = -1; busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
        if (obs_b[i] !== exp_v[i]) begin bad++; if (first < 0) first = i; end
        if (obs_b[i][2] === 1'b1) busy_cnt++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL boundary_%02h %0d bad cycles, first at %0d got=%b want=%b",
                 b, bad, first, obs_b[first], exp_v[first]);
      end
      checks++;
      if (busy_cnt != 20) begin failures++; $display("FAIL boundary_len busy cycles got=%0d want=20", busy_cnt); end
    end
  endtask

  task automatic test_pop_safety;
    checks++;
    if (underflow !== 0) begin failures++; $display("FAIL pop_on_empty got=%0d want=0", underflow); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_empty();
    test_drain(4, 8'h00, 8'hFF, 8'h55, 8'h81, 1'b0);
    test_drain(int'($urandom_range(1, 4)), 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    test_gate();
    test_async_reset();
    test_boundary();
    test_pop_safety();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_buffer_tx.md
# uart_buffer_tx

Serial transmitter that drains the byte circular buffer sitting between the core and the UART pins. It watches the buffer's available-space count, pops one byte at a time through the buffer's read port, and shifts each byte out as an 8N1 frame (1 start, 8 data LSB first, 1 stop) on `tx`. One instance sits on the transmit side of each serial link; the buffer's write port stays with the producer.

## Interface
- `BUFFER_BYTE_SIZE`, 4: capacity of the attached buffer; power of 2, ≥ 2.
- `BUFFER_ADDR_SIZE`, `$clog2(BUFFER_BYTE_SIZE)`: buffer address width.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit; ≥ 2.

- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low; low forces reset state immediately.
- `tx_en`  input  1  permission to start new frames; sampled only in IDLE.
- `buf_size_avai`  input  `BUFFER_ADDR_SIZE+1`  free-slot count from the buffer; empty when equal to `BUFFER_BYTE_SIZE`.
- `buf_output_data`  input  8  byte at the buffer's read pointer, valid combinationally.
- `buf_output_en`  output  1  pop strobe to the buffer; registered, one-cycle pulse.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high in any state other than IDLE.
- `tx_done`  output  1  one-cycle pulse at the end of each stop bit.

## Operation
- States: IDLE, START, DATA, STOP. Registers: 8-bit shift register, 3-bit bit index, bit-time counter of width `$clog2(CLKS_PER_BIT)`.
- Reset values: state IDLE, `tx`=1, `busy`=0, `buf_output_en`=0, `tx_done`=0, counters 0, shift register 0.
- IDLE: if `tx_en`=1 and `buf_size_avai` != `BUFFER_BYTE_SIZE`, latch `buf_output_data` into the shift register, set `buf_output_en`=1, set `tx`=0, clear counters, go to START. Otherwise remain, `tx`=1.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles. On the last cycle, drive `tx`=shift[0] and go to DATA.
- DATA: each bit is held `CLKS_PER_BIT` cycles. At each bit end, shift right, increment the bit index, and drive the next bit. After bit 7 the line goes `tx`=1 and the block goes to STOP.
- STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, set `tx_done`=1 for that edge's following cycle and go to IDLE.
- `buf_output_en` clears on the edge after it was set. Exactly one pop occurs per frame. It is never asserted while the buffer is empty.
- `tx_en` deasserted mid-frame: the current frame completes normally, and no further pop occurs.
- `buf_size_avai` changes mid-frame are ignored. Emptiness is evaluated only in IDLE.
- A byte written into an empty buffer is first visible to IDLE on the cycle after the buffer's count updates.
- `reset` low at any time, including mid-frame: `tx` returns to 1 and `buf_output_en` returns to 0 asynchronously. The partial frame is abandoned and the popped byte is lost.
- Reset release is synchronized by the parent. The first possible start occurs on the first rising edge after `reset` is high.

## Timing
- Pop-to-line latency: `tx` falls on the same edge that sets `buf_output_en`, so the start bit begins in the cycle after IDLE sees a non-empty buffer.
- Frame length: exactly `10*CLKS_PER_BIT` cycles from `tx` falling to the end of the stop bit.
- Back-to-back frames: IDLE lasts one cycle minimum, so the frame period is `10*CLKS_PER_BIT+1` cycles while the buffer is non-empty.
- The buffer pointer advances at the end of the `buf_output_en` cycle, one full frame before the next read of `buf_output_data`.
- `busy` rises with `tx` falling and falls with the STOP→IDLE edge. `tx_done` coincides with the first IDLE cycle.

## Test plan
- Single byte: `CLKS_PER_BIT`=4; buffer holds 0xA5; `tx_en`=1. Required: one `buf_output_en` pulse; `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; one `tx_done` pulse; `busy` high for 40 cycles.
- Drain full buffer: 4 bytes 0x00, 0xFF, 0x55, 0x81. Required: 4 frames in order, 41-cycle period; exactly 4 pops; `tx` stays high once `buf_size_avai`=4.
- Empty buffer: `buf_size_avai`=4 and `tx_en`=1 for 100 cycles. Required: no `buf_output_en`; `tx`=1; `busy`=0.
- Gate: deassert `tx_en` during the DATA bits of frame 1 while 2 bytes are queued. Required: frame 1 completes intact; no second pop until `tx_en` returns to 1.
- Async reset mid-frame: pull `reset` low in the middle of data bit 3. Required: `tx`=1 and `busy`=0 before the next clock edge. After release with the buffer non-empty, a fresh frame starts from its start bit.
- Boundary: `CLKS_PER_BIT`=2, byte 0x80. Required: 20-cycle frame; bit 7 high for exactly 2 cycles, followed by the 2-cycle stop bit.
